sap_obi_one_to_n_demux: RTL

SAP_OBI_ONE_TO_N_DEMUX -- requirements
Module: sap_obi_one_to_n_demux

---
 rtl/sap_obi_one_to_n_demux.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sap_obi_one_to_n_demux.sv
// One-master to N-slave OBI demultiplexer.
// The address decoder picks a slave. A decode miss or a response timeout is
// answered locally with an error rvalid. Slaves that timed out are fenced off
// until their late rvalid arrives and is dropped.

package sap_obi_one_to_n_demux_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module sap_obi_one_to_n_demux
  import sap_obi_one_to_n_demux_pkg::*;
#(
  parameter int unsigned             NSLAVE     = 2,
  parameter logic [NSLAVE-1:0][31:0] SLAVE_BASE = '0,
  parameter logic [NSLAVE-1:0][31:0] SLAVE_MASK = '0,
  parameter int unsigned             TIMEOUT    = 256,
  parameter logic [31:0]             ERR_RDATA  = 32'hBADACCE5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  obi_req_t               master_req_i,
  output obi_resp_t              master_resp_o,
  output obi_req_t  [NSLAVE-1:0] slave_req_o,
  input  obi_resp_t [NSLAVE-1:0] slave_resp_i,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int unsigned SEL_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RVALID,
    ERR_RESP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NSLAVE-1:0]  stale_q;
  logic [NSLAVE-1:0]  stale_d;

  logic               hit;
  logic [SEL_W-1:0]   hit_idx;
  logic               wait_st;
  logic               sel_rvalid;
  logic               accept;
  logic               issue_hit;
  logic               issue_gnt;
  logic               issue_miss;
  logic               timeout;

  // Address decode: the first (lowest-index) matching slave wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (!hit && ((master_req_i.addr & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Issue qualifiers shared by next-state and output logic. A new request is
  // accepted in IDLE, or in WAIT_RVALID on the very cycle the outstanding
  // response returns, which gives zero-bubble back-to-back transfers.
  always_comb begin
    wait_st    = (state_q == WAIT_RVALID);
    sel_rvalid = wait_st && slave_resp_i[sel_q].rvalid && !stale_q[sel_q];
    accept     = (state_q == IDLE) || sel_rvalid;
    issue_hit  = accept && master_req_i.req && hit && !stale_q[hit_idx];
    issue_gnt  = issue_hit && slave_resp_i[hit_idx].gnt;
    issue_miss = accept && master_req_i.req && !hit;
    timeout    = wait_st && !sel_rvalid && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Stale tracking: set on timeout and cleared by the slave's late rvalid.
  // A timeout implies that the selected slave gave no rvalid, so the set and
  // the clear never hit the same bit in the same cycle.
  always_comb begin
    stale_d = stale_q;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (stale_q[i] && slave_resp_i[i].rvalid) begin
        stale_d[i] = 1'b0;
      end
    end
    if (timeout) begin
      stale_d[sel_q] = 1'b1;
    end
  end

  // State register plus selected-slave, timeout counter and stale flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
      if (issue_gnt) begin
        sel_q <= hit_idx;
        cnt_q <= '0;
      end else if (wait_st && !sel_rvalid && !timeout) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue_gnt) begin
          state_d = WAIT_RVALID;
        end else if (issue_miss) begin
          state_d = ERR_RESP;
        end
      end
      WAIT_RVALID: begin
        if (sel_rvalid) begin
          if (issue_gnt) begin
            state_d = WAIT_RVALID;
          end else if (issue_miss) begin
            state_d = ERR_RESP;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout) begin
          state_d = ERR_RESP;
        end
      end
      ERR_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic. All handshakes are forced low while reset is held.
  always_comb begin
    master_resp_o = '0;
    err_o         = 1'b0;
    busy_o        = 1'b0;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      slave_req_o[i]     = master_req_i;
      slave_req_o[i].req = 1'b0;
    end
    if (!rst_i) begin
      if (issue_hit) begin
        slave_req_o[hit_idx].req = 1'b1;
      end
      master_resp_o.gnt = issue_gnt || issue_miss;
      if (sel_rvalid) begin
        master_resp_o.rvalid = 1'b1;
        master_resp_o.rdata  = slave_resp_i[sel_q].rdata;
      end else if (state_q == ERR_RESP) begin
        master_resp_o.rvalid = 1'b1;
        master_resp_o.rdata  = ERR_RDATA;
        err_o                = 1'b1;
      end
      busy_o = (state_q != IDLE);
    end
  end

endmodule
